// File: rtl/pipe_buf_pkg.sv
// pipe_buf_pkg: reset level, default sizing and slice state encoding shared by pipe_buf and pipe_buf_slot.
// Optional occupancy counter in pipe_buf is enabled with PIPE_BUF_OCCUPANCY_EN.
package pipe_buf_pkg;

    localparam logic RST_ACTIVE    = 1'b0;
    localparam int   DEFAULT_WIDTH = 32;
    localparam int   DEFAULT_DEPTH = 1;

    // Bit 0 = main register valid, bit 1 = skid register valid.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_MAIN  = 2'b01,
        SLOT_FULL  = 2'b11
    } slot_state_e;

    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_buf_slot.sv
// pipe_buf_slot: one elastic slice with a main register and a one-entry skid register.
// Upstream ready comes straight from the skid flop, so no ready path crosses the slice.
module pipe_buf_slot
    import pipe_buf_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] FLUSH_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pause,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    slot_state_e      r_state;
    slot_state_e      w_state_next;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;

    logic w_m_valid;
    logic w_s_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_m_valid  = (r_state != SLOT_EMPTY);
    assign w_s_valid  = (r_state == SLOT_FULL);
    assign o_valid    = w_m_valid;
    assign o_ready    = ~w_s_valid;
    assign o_data     = r_m_data;
    assign w_in_fire  = i_valid & ~w_s_valid & ~i_pause;
    assign w_out_fire = w_m_valid & i_ready & ~i_pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = SLOT_EMPTY;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (w_in_fire) w_state_next = SLOT_MAIN;
                end
                SLOT_MAIN: begin
                    if (w_in_fire && !w_out_fire)      w_state_next = SLOT_FULL;
                    else if (!w_in_fire && w_out_fire) w_state_next = SLOT_EMPTY;
                end
                SLOT_FULL: begin
                    if (w_out_fire) w_state_next = SLOT_MAIN;
                end
                default: w_state_next = SLOT_EMPTY;
            endcase
        end
    end

    // Simultaneous accept and drain on a held main bypasses the skid entirely.
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            SLOT_EMPTY: w_load_main_in = w_in_fire;
            SLOT_MAIN: begin
                w_load_main_in = w_in_fire & w_out_fire;
                w_load_skid    = w_in_fire & ~w_out_fire;
            end
            SLOT_FULL:  w_load_main_skid = w_out_fire;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE) begin
            r_m_data <= FLUSH_DATA;
            r_s_data <= FLUSH_DATA;
        end else if (i_flush) begin
            r_m_data <= FLUSH_DATA;
            r_s_data <= FLUSH_DATA;
        end else begin
            if (w_load_main_in)        r_m_data <= i_data;
            else if (w_load_main_skid) r_m_data <= r_s_data;
            if (w_load_skid)           r_s_data <= i_data;
        end
    end

endmodule

// File: rtl/pipe_buf.sv
// pipe_buf: DEPTH chained elastic slices (2*DEPTH entries) with global pause and synchronous flush.
// Define PIPE_BUF_OCCUPANCY_EN to add the o_count occupancy output.
module pipe_buf
    import pipe_buf_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter int               DEPTH      = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] FLUSH_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pause,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data
`ifdef PIPE_BUF_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] o_count
`endif
);

    // Index k is the boundary in front of slice k; index DEPTH is the buffer output.
    logic             w_valid [DEPTH+1];
    logic [WIDTH-1:0] w_data  [DEPTH+1];
    logic             w_ready [DEPTH+1];

    assign w_valid[0]     = i_in_valid;
    assign w_data[0]      = i_in_data;
    assign w_ready[DEPTH] = i_out_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            pipe_buf_slot #(
                .WIDTH      (WIDTH),
                .FLUSH_DATA (FLUSH_DATA)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_pause (i_pause),
                .i_flush (i_flush),
                .i_valid (w_valid[gi]),
                .i_data  (w_data[gi]),
                .o_ready (w_ready[gi]),
                .o_valid (w_valid[gi+1]),
                .o_data  (w_data[gi+1]),
                .i_ready (w_ready[gi+1])
            );
        end
    endgenerate

    assign o_in_ready  = w_ready[0] & ~i_pause;
    assign o_out_valid = w_valid[DEPTH];
    assign o_out_data  = w_data[DEPTH];

`ifdef PIPE_BUF_OCCUPANCY_EN
    localparam int CNT_W = occ_width(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = i_in_valid & o_in_ready;
    assign w_out_fire = o_out_valid & i_out_ready & ~i_pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_count <= r_count + 1'b1;
        end else if (!w_in_fire && w_out_fire) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
`endif

endmodule
